instr_prefetch_queue: RTL and testbench

//  Instruction prefetch front-end. Sits between instruction memory and the IF/ID pipeline register.

---
 rtl/cpu_pkg.sv | 10 +
 rtl/ifq_fifo.sv | 51 +++++
 rtl/instr_prefetch_queue.sv | 108 ++++++++++
 tb/tb_instr_prefetch_queue.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU front-end types and constants for the instruction prefetch queue.
package cpu_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } ifq_entry_t;
endpackage

// File: rtl/ifq_fifo.sv
// In-order synchronous FIFO of fetched {instr, pc} entries with a flush-style clear.
module ifq_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   clear,
    input  ifq_entry_t             din,
    output ifq_entry_t             head,
    output logic [$clog2(DEPTH):0] occupancy,
    output logic                   empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          full;
    ifq_entry_t    mem [DEPTH];

    assign full  = (occupancy == (AW+1)'(DEPTH));
    assign empty = (occupancy == '0);
    assign head  = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else if (clear) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            occupancy <= occupancy + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    // Data storage needs no reset; validity is tracked by occupancy alone.
    always_ff @(posedge clk) begin
        if (push && !clear) mem[wr_ptr] <= din;
    end

    // The issue gate reserves a slot per outstanding request, so this never fires.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        !(push && !pop && !clear && full));
endmodule

// File: rtl/instr_prefetch_queue.sv
// Sequential instruction prefetcher with redirect/discard and an in-order response queue.
// Optional perf counters enabled by defining PREFETCH_PERF_EN.
module instr_prefetch_queue
    import cpu_pkg::*;
#(
    parameter int              DEPTH           = 4,
    parameter int              MAX_OUTSTANDING = 2,
    parameter logic [XLEN-1:0] RESET_PC        = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    input  logic            stall,
    output logic            instr_valid,
    output logic [XLEN-1:0] instruction,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] next_pc
`ifdef PREFETCH_PERF_EN
   ,output logic [31:0]     perf_fetch_cnt,
    output logic [31:0]     perf_discard_cnt
`endif
);
    localparam int OW  = $clog2(MAX_OUTSTANDING + 1);
    localparam int OCW = $clog2(DEPTH) + 1;

    logic [OW-1:0]   outstanding, discard;
    logic [XLEN-1:0] fetch_addr, rsp_pc, target_aligned;
    logic [OCW-1:0]  occupancy;
    logic            empty, grant, push, pop, drop;
    ifq_entry_t      head;

    assign target_aligned = branch_target & ~32'h3;

    // Gating with rst keeps the request low while held in reset yet lets the
    // first fetch go out in the very first cycle after release.
    always_comb begin
        imem_req = rst && !branch_taken
                && (int'(outstanding) < MAX_OUTSTANDING)
                && (int'(occupancy) + int'(outstanding) < DEPTH);
        grant    = imem_req && imem_gnt;
        drop     = imem_rvalid && (discard != '0);
        push     = imem_rvalid && (discard == '0) && !branch_taken;
        pop      = instr_valid && !stall && !branch_taken;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_addr  <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            outstanding <= outstanding + OW'(grant) - OW'(imem_rvalid);
            if (branch_taken) begin
                // Every request still in flight belongs to the old stream.
                fetch_addr <= target_aligned;
                rsp_pc     <= target_aligned;
                discard    <= outstanding - OW'(imem_rvalid);
            end else begin
                if (grant) fetch_addr <= fetch_addr + 32'd4;
                if (push)  rsp_pc     <= rsp_pc + 32'd4;
                if (drop)  discard    <= discard - OW'(1);
            end
        end
    end

    ifq_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .clear     (branch_taken),
        .din       ('{instr: imem_rdata, pc: rsp_pc}),
        .head      (head),
        .occupancy (occupancy),
        .empty     (empty)
    );

    assign imem_addr   = fetch_addr;
    assign instr_valid = !empty;
    assign instruction = instr_valid ? head.instr : NOP_INSTR;
    assign pc          = instr_valid ? head.pc : rsp_pc;
    assign next_pc     = pc + 32'd4;

    a_rsp_expected: assert property (@(posedge clk) disable iff (!rst)
        imem_rvalid |-> (outstanding != '0));

`ifdef PREFETCH_PERF_EN
    // A response lost to a flush in its arrival cycle counts as dropped too.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_fetch_cnt   <= '0;
            perf_discard_cnt <= '0;
        end else begin
            if (grant && perf_fetch_cnt != '1)
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            if (imem_rvalid && !push && perf_discard_cnt != '1)
                perf_discard_cnt <= perf_discard_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Directed bench for instr_prefetch_queue with a latency-programmable memory model.
module tb_instr_prefetch_queue;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req, imem_gnt, imem_rvalid;
    logic [31:0] imem_addr, imem_rdata;
    logic        branch_taken, stall, instr_valid;
    logic [31:0] branch_target, instruction, pc, next_pc;
`ifdef PREFETCH_PERF_EN
    logic [31:0] perf_fetch_cnt, perf_discard_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int lat    = 1;
    int mcyc   = 0;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;
    pend_t pq[$];

    instr_prefetch_queue dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_gnt      (imem_gnt),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .stall         (stall),
        .instr_valid   (instr_valid),
        .instruction   (instruction),
        .pc            (pc),
        .next_pc       (next_pc)
`ifdef PREFETCH_PERF_EN
       ,.perf_fetch_cnt   (perf_fetch_cnt),
        .perf_discard_cnt (perf_discard_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Memory: word at addr is addr ^ C000_0000; response 'lat' cycles after grant.
    always @(negedge clk) begin
        mcyc++;
        imem_rvalid = 1'b0;
        if (!rst) begin
            pq.delete();
        end else begin
            if (pq.size() > 0 && pq[0].due <= mcyc) begin
                imem_rvalid = 1'b1;
                imem_rdata  = pq[0].addr ^ 32'hC000_0000;
                void'(pq.pop_front());
            end
            if (imem_req && imem_gnt) pq.push_back('{addr: imem_addr, due: mcyc + lat});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut(input int l);
        rst = 1'b0;
        lat = l;
        branch_taken = 1'b0;
        stall = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        tick();
        tick();
        #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req got %b exp 0", imem_req); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL rst_addr got %h exp 00000000", imem_addr); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", instr_valid); end
        checks++; if (instruction !== 32'h13) begin errors++; $display("FAIL rst_instr got %h exp 00000013", instruction); end
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL rst_pc got %h exp 00000000", pc); end
        tick();
        rst = 1'b1;
    endtask

    // Cycles 0..7 after release; zero-wait memory.
    task automatic test_stream();
        for (int k = 0; k < 8; k++) begin
            #1;
            checks++; if (imem_req !== 1'b1 || imem_addr !== 32'(4*k)) begin errors++; $display("FAIL stream_req c%0d got %b/%h exp 1/%h", k, imem_req, imem_addr, 32'(4*k)); end
            if (k < 2) begin
                checks++; if (instr_valid !== 1'b0 || instruction !== 32'h13) begin errors++; $display("FAIL stream_empty c%0d got %b/%h exp 0/00000013", k, instr_valid, instruction); end
            end else begin
                checks++; if (instr_valid !== 1'b1 || pc !== 32'(4*(k-2))) begin errors++; $display("FAIL stream_pc c%0d got %b/%h exp 1/%h", k, instr_valid, pc, 32'(4*(k-2))); end
                checks++; if (instruction !== (32'(4*(k-2)) ^ 32'hC000_0000) || next_pc !== 32'(4*(k-1))) begin errors++; $display("FAIL stream_data c%0d got %h/%h", k, instruction, next_pc); end
            end
            tick();
        end
    endtask

    // Head pc is 24 at entry; stall five cycles then drain.
    task automatic test_stall();
        for (int j = 0; j < 5; j++) begin
            stall = 1'b1;
            #1;
            checks++; if (instr_valid !== 1'b1 || pc !== 32'd24) begin errors++; $display("FAIL stall_hold c%0d got %b/%h exp 1/00000018", j, instr_valid, pc); end
            if (j >= 2) begin
                checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL stall_req c%0d got %b exp 0", j, imem_req); end
            end
            tick();
        end
        for (int i = 0; i < 8; i++) begin
            stall = 1'b0;
            #1;
            checks++; if (instr_valid !== 1'b1 || pc !== 32'(24 + 4*i)) begin errors++; $display("FAIL drain c%0d got %b/%h exp 1/%h", i, instr_valid, pc, 32'(24 + 4*i)); end
            tick();
        end
    endtask

    // 3-cycle memory; flush with two requests in flight, then async reset.
    task automatic test_flush_stale();
        reset_dut(3);
        for (int c = 0; c < 10; c++) begin
            branch_taken  = (c == 2);
            branch_target = 32'h100;
            #1;
            if (c == 2) begin
                checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL fl_req_blocked got %b exp 0", imem_req); end
            end
            if (c >= 3 && c <= 7) begin
                checks++; if (instr_valid !== 1'b0 || instruction !== 32'h13) begin errors++; $display("FAIL fl_stale c%0d got %b/%h exp 0/00000013", c, instr_valid, instruction); end
            end
            if (c == 4) begin
                checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin errors++; $display("FAIL fl_refetch got %b/%h exp 1/00000100", imem_req, imem_addr); end
            end
            if (c == 8) begin
                checks++; if (instr_valid !== 1'b1 || pc !== 32'h100 || instruction !== 32'hC000_0100 || next_pc !== 32'h104) begin errors++; $display("FAIL fl_target got %b/%h/%h/%h exp 1/00000100/c0000100/00000104", instr_valid, pc, instruction, next_pc); end
            end
            if (c == 9) begin
                checks++; if (pc !== 32'h104) begin errors++; $display("FAIL fl_next got %h exp 00000104", pc); end
`ifdef PREFETCH_PERF_EN
                checks++; if (perf_discard_cnt !== 32'd2) begin errors++; $display("FAIL perf_discard got %0d exp 2", perf_discard_cnt); end
                checks++; if (perf_fetch_cnt !== 32'd5) begin errors++; $display("FAIL perf_fetch got %0d exp 5", perf_fetch_cnt); end
`endif
                rst = 1'b0;
                #1;
                checks++; if (imem_req !== 1'b0 || instr_valid !== 1'b0 || instruction !== 32'h13 || pc !== 32'h0 || imem_addr !== 32'h0) begin errors++; $display("FAIL async_rst got %b/%b/%h/%h/%h", imem_req, instr_valid, instruction, pc, imem_addr); end
`ifdef PREFETCH_PERF_EN
                checks++; if (perf_fetch_cnt !== 32'd0 || perf_discard_cnt !== 32'd0) begin errors++; $display("FAIL async_rst_perf got %0d/%0d exp 0/0", perf_fetch_cnt, perf_discard_cnt); end
`endif
            end
            if (c < 9) tick();
        end
        branch_taken = 1'b0;
    endtask

    // Flush coinciding with a response and a pop; then a wrap-around fetch under stall.
    task automatic test_flush_rvalid_pop_and_wrap();
        reset_dut(1);
        for (int c = 0; c < 12; c++) begin
            branch_taken  = (c == 2) || (c == 6);
            branch_target = (c == 2) ? 32'h103 : 32'hFFFF_FFF8;
            stall         = (c == 6);
            #1;
            if (c == 2) begin
                checks++; if (instr_valid !== 1'b1 || pc !== 32'h0 || imem_req !== 1'b0) begin errors++; $display("FAIL f4_pre got %b/%h/%b exp 1/00000000/0", instr_valid, pc, imem_req); end
            end
            if (c == 3) begin
                checks++; if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100) begin errors++; $display("FAIL f4_clear got %b/%b/%h exp 0/1/00000100", instr_valid, imem_req, imem_addr); end
            end
            if (c == 4) begin
                checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL f4_gap got %b exp 0", instr_valid); end
            end
            if (c == 5) begin
                checks++; if (instr_valid !== 1'b1 || pc !== 32'h100 || instruction !== 32'hC000_0100) begin errors++; $display("FAIL f4_target got %b/%h/%h exp 1/00000100/c0000100", instr_valid, pc, instruction); end
            end
            if (c == 7) begin
                checks++; if (instr_valid !== 1'b0 || imem_addr !== 32'hFFFF_FFF8) begin errors++; $display("FAIL wrap_start got %b/%h exp 0/fffffff8", instr_valid, imem_addr); end
            end
            if (c == 9) begin
                checks++; if (instr_valid !== 1'b1 || pc !== 32'hFFFF_FFF8 || imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_pc0 got %b/%h/%h exp 1/fffffff8/00000000", instr_valid, pc, imem_addr); end
            end
            if (c == 10) begin
                checks++; if (pc !== 32'hFFFF_FFFC || next_pc !== 32'h0) begin errors++; $display("FAIL wrap_pc1 got %h/%h exp fffffffc/00000000", pc, next_pc); end
            end
            if (c == 11) begin
                checks++; if (instr_valid !== 1'b1 || pc !== 32'h0 || instruction !== 32'hC000_0000) begin errors++; $display("FAIL wrap_pc2 got %b/%h/%h exp 1/00000000/c0000000", instr_valid, pc, instruction); end
            end
            tick();
        end
        branch_taken = 1'b0;
        stall = 1'b0;
    endtask

    initial begin
        imem_gnt      = 1'b1;
        imem_rvalid   = 1'b0;
        imem_rdata    = '0;
        branch_taken  = 1'b0;
        branch_target = '0;
        stall         = 1'b0;
        test_reset();
        test_stream();
        test_stall();
        test_flush_stale();
        test_flush_rvalid_pop_and_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
